// File: rtl/sipo_rx_pkg.sv
// Shared types and sizing helpers for the sipo_rx serial receiver.
// SIPO_RX_PARITY_EN adds one trailing even-parity bit to every frame.
package sipo_rx_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

`ifdef SIPO_RX_PARITY_EN
  localparam int PARITY_BITS = 1;
`else
  localparam int PARITY_BITS = 0;
`endif

  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

  function automatic int frame_bits(input int width);
    return width + PARITY_BITS;
  endfunction

endpackage

// File: rtl/sipo_out_reg.sv
// One-entry valid/ready holding register; a load that finds it full is dropped
// and raises the sticky overrun flag (set beats clear).
module sipo_out_reg #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_ready,
  input  logic             i_ovr_clr,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  output logic             o_overrun
);

  logic [WIDTH-1:0] r_data;
  logic             r_valid;
  logic             r_overrun;
  logic             w_full;

  // full means the held word will not be taken this cycle
  assign w_full = r_valid & ~i_ready;

  // word register, valid flag and sticky overrun
  always_ff @(posedge clk) begin
    if (reset) begin
      r_data    <= {WIDTH{1'b0}};
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if (i_load && !w_full) begin
        r_data  <= i_data;
        r_valid <= 1'b1;
      end else if (r_valid && i_ready) begin
        r_valid <= 1'b0;
      end else begin
        r_valid <= r_valid;
      end

      if (i_load && w_full) begin
        r_overrun <= 1'b1;
      end else if (i_ovr_clr) begin
        r_overrun <= 1'b0;
      end else begin
        r_overrun <= r_overrun;
      end
    end
  end

  assign o_data    = r_data;
  assign o_valid   = r_valid;
  assign o_overrun = r_overrun;

endmodule

// File: rtl/sipo_rx.sv
// LSB-first serial-in/parallel-out frame receiver with a valid/ready output.
// Define SIPO_RX_PARITY_EN for a trailing even-parity bit and the parity_err port.
module sipo_rx
  import sipo_rx_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = cnt_width(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sin_valid,
  input  logic             sin_data,
  input  logic             sin_start,
  output logic [WIDTH-1:0] pout_data,
  output logic             pout_valid,
  input  logic             pout_ready,
  output logic             busy,
  output logic             overrun,
  input  logic             overrun_clr,
`ifdef SIPO_RX_PARITY_EN
  output logic             parity_err,
`endif
  output logic             frame_err
);

  localparam int               FRAME_BITS = frame_bits(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT   = CNT_W'(FRAME_BITS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  state_e           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0] r_shreg, w_shreg_nxt, w_shifted, w_word;
  logic             w_done, w_restart, w_par_bad, w_load;
  logic             r_frame_err;

  assign w_shifted = (r_shreg >> 1) | {sin_data, {(WIDTH-1){1'b0}}};

  // with parity the closing bit is a check bit, so the word is already assembled
`ifdef SIPO_RX_PARITY_EN
  logic r_parity_err;
  assign w_word    = r_shreg;
  assign w_par_bad = (^r_shreg) ^ sin_data;
`else
  assign w_word    = w_shifted;
  assign w_par_bad = 1'b0;
`endif

  assign w_load = w_done & ~w_par_bad;

  // next-state, bit counter and shifter
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_shreg_nxt = r_shreg;
    w_done      = 1'b0;
    w_restart   = 1'b0;
    case (r_state)
      IDLE: begin
        if (sin_valid && sin_start) begin
          w_shreg_nxt = w_shifted;
          w_cnt_nxt   = CNT_ONE;
          w_state_nxt = SHIFT;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      SHIFT: begin
        if (!sin_valid) begin
          w_state_nxt = SHIFT;
        end else if (sin_start) begin
          w_restart   = 1'b1;
          w_shreg_nxt = w_shifted;
          w_cnt_nxt   = CNT_ONE;
        end else if (r_cnt == LAST_CNT) begin
          w_done      = 1'b1;
          w_shreg_nxt = w_word;
          w_cnt_nxt   = {CNT_W{1'b0}};
          w_state_nxt = IDLE;
        end else begin
          w_shreg_nxt = w_shifted;
          w_cnt_nxt   = r_cnt + CNT_ONE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = {CNT_W{1'b0}};
        w_shreg_nxt = {WIDTH{1'b0}};
      end
    endcase
  end

  // state, counter, shifter and error pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_cnt        <= {CNT_W{1'b0}};
      r_shreg      <= {WIDTH{1'b0}};
      r_frame_err  <= 1'b0;
`ifdef SIPO_RX_PARITY_EN
      r_parity_err <= 1'b0;
`endif
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_shreg      <= w_shreg_nxt;
      r_frame_err  <= w_restart;
`ifdef SIPO_RX_PARITY_EN
      r_parity_err <= w_done & w_par_bad;
`endif
    end
  end

  sipo_out_reg #(.WIDTH(WIDTH)) u_out_reg (
    .clk       (clk),
    .reset     (reset),
    .i_load    (w_load),
    .i_data    (w_word),
    .i_ready   (pout_ready),
    .i_ovr_clr (overrun_clr),
    .o_data    (pout_data),
    .o_valid   (pout_valid),
    .o_overrun (overrun)
  );

  assign busy      = (r_state == SHIFT);
  assign frame_err = r_frame_err;
`ifdef SIPO_RX_PARITY_EN
  assign parity_err = r_parity_err;
`endif

endmodule

// File: tb/tb_sipo_rx.sv
// Scoreboard bench for sipo_rx: stimulus pushes expected words, a negedge
// monitor pops and compares on every pout_valid & pout_ready transfer.
module tb_sipo_rx;

  localparam int WIDTH = 4;
`ifdef SIPO_RX_PARITY_EN
  localparam int FBITS = WIDTH + 1;
`else
  localparam int FBITS = WIDTH;
`endif

  logic             clk = 1'b0;
  logic             reset, sin_valid, sin_data, sin_start;
  logic [WIDTH-1:0] pout_data;
  logic             pout_valid, pout_ready, busy, overrun, overrun_clr, frame_err;
`ifdef SIPO_RX_PARITY_EN
  logic             parity_err;
`endif

  int               n_checks = 0;
  int               n_fail   = 0;
  int               fe_cnt   = 0;
  logic [WIDTH-1:0] exp_q[$];

  sipo_rx #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .sin_valid   (sin_valid),
    .sin_data    (sin_data),
    .sin_start   (sin_start),
    .pout_data   (pout_data),
    .pout_valid  (pout_valid),
    .pout_ready  (pout_ready),
    .busy        (busy),
    .overrun     (overrun),
    .overrun_clr (overrun_clr),
`ifdef SIPO_RX_PARITY_EN
    .parity_err  (parity_err),
`endif
    .frame_err   (frame_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor: scoreboard pop on each transfer, plus frame_err pulse count
  always @(negedge clk) begin
    if (!reset && frame_err) fe_cnt++;
    if (!reset && pout_valid && pout_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_word: got %0h expected no transfer", pout_data);
      end else begin
        check("scoreboard_word", 32'(pout_data), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic start, input logic data);
    sin_valid = 1'b1;
    sin_start = start;
    sin_data  = data;
    tick();
    sin_valid = 1'b0;
    sin_start = 1'b0;
    sin_data  = 1'b0;
  endtask

  // full frame (plus parity bit when enabled); optionally raise ready with the last bit
  task automatic send_frame(input logic [WIDTH-1:0] word, input int gap,
                            input logic bad_par, input logic rdy_last);
    logic b;
    for (int i = 0; i < FBITS; i++) begin
      if (i < WIDTH) b = word[i];
      else           b = (^word) ^ bad_par;
      if (rdy_last && i == FBITS - 1) pout_ready = 1'b1;
      send_bit(i == 0, b);
      check("busy_during_frame", 32'(busy), 32'(i < FBITS - 1));
      if (i < FBITS - 1) repeat (gap) tick();
    end
  endtask

  initial begin
    reset = 1'b1; sin_valid = 1'b0; sin_data = 1'b0; sin_start = 1'b0;
    pout_ready = 1'b1; overrun_clr = 1'b0;
    tick(); tick();
    reset = 1'b0;
    check("rst_pout_data", 32'(pout_data), 32'h0);
    check("rst_pout_valid", 32'(pout_valid), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_overrun", 32'(overrun), 32'h0);
    check("rst_frame_err", 32'(frame_err), 32'h0);

    // 1: basic frame, valid for exactly one cycle
    exp_q.push_back(4'b1101);
    send_frame(4'b1101, 0, 1'b0, 1'b0);
    check("t1_valid", 32'(pout_valid), 32'h1);
    check("t1_data", 32'(pout_data), 32'hD);
    tick();
    check("t1_valid_clear", 32'(pout_valid), 32'h0);

    // 2: gaps between strobes hold state
    exp_q.push_back(4'b0011);
    send_frame(4'b0011, 3, 1'b0, 1'b0);
    check("t2_valid", 32'(pout_valid), 32'h1);
    tick();

    // 3: overrun with consumer stalled
    pout_ready = 1'b0;
    exp_q.push_back(4'hA);
    send_frame(4'hA, 0, 1'b0, 1'b0);
    check("t3_overrun_pre", 32'(overrun), 32'h0);
    send_frame(4'h5, 0, 1'b0, 1'b0);
    check("t3_data_held", 32'(pout_data), 32'hA);
    check("t3_overrun_set", 32'(overrun), 32'h1);
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    check("t3_overrun_clr", 32'(overrun), 32'h0);
    pout_ready = 1'b1;
    tick();
    check("t3_valid_after_xfer", 32'(pout_valid), 32'h0);

    // 4: start mid-frame restarts and pulses frame_err
    fe_cnt = 0;
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b0);
    exp_q.push_back(4'b1110);
    send_frame(4'b1110, 0, 1'b0, 1'b0);
    check("t4_data", 32'(pout_data), 32'hE);
    tick();
    check("t4_frame_err_pulses", 32'(fe_cnt), 32'h1);

    // 5a: transfer and completion in the same cycle
    pout_ready = 1'b0;
    exp_q.push_back(4'h3);
    send_frame(4'h3, 0, 1'b0, 1'b0);
    exp_q.push_back(4'hC);
    send_frame(4'hC, 0, 1'b0, 1'b1);
    check("t5_valid_stays", 32'(pout_valid), 32'h1);
    check("t5_new_data", 32'(pout_data), 32'hC);
    check("t5_no_overrun", 32'(overrun), 32'h0);
    tick();
    check("t5_valid_clear", 32'(pout_valid), 32'h0);

    // 5b: reset mid-frame with a held word
    pout_ready = 1'b0;
    send_frame(4'h9, 0, 1'b0, 1'b0);
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t5_rst_data", 32'(pout_data), 32'h0);
    check("t5_rst_valid", 32'(pout_valid), 32'h0);
    check("t5_rst_busy", 32'(busy), 32'h0);
    check("t5_rst_overrun", 32'(overrun), 32'h0);
    check("t5_rst_frame_err", 32'(frame_err), 32'h0);
    pout_ready = 1'b1;
    exp_q.push_back(4'h6);
    send_frame(4'h6, 1, 1'b0, 1'b0);
    check("t5_post_rst_data", 32'(pout_data), 32'h6);
    tick();

`ifdef SIPO_RX_PARITY_EN
    // 6: good parity passes, bad parity is discarded
    exp_q.push_back(4'b1101);
    send_frame(4'b1101, 0, 1'b0, 1'b0);
    check("t6_good_valid", 32'(pout_valid), 32'h1);
    check("t6_good_perr", 32'(parity_err), 32'h0);
    tick();
    send_frame(4'b1101, 0, 1'b1, 1'b0);
    check("t6_bad_perr", 32'(parity_err), 32'h1);
    check("t6_bad_valid", 32'(pout_valid), 32'h0);
    tick();
    check("t6_perr_clear", 32'(parity_err), 32'h0);
    check("t6_bad_overrun", 32'(overrun), 32'h0);
`endif

    tick(); tick();
    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
